router_out_arbiter: RTL

Wormhole output-port arbiter for the NoC router. It shares one outgoing 68-bit router channel between NUM_IN input requesters and grants round-robin on packet head flits. It holds the grant until the tail flit and meters flits against a downstream credit counter fed by the channel's flow-control wires. It sits between the router's input buffers and the registered output channel stage.

---
 rtl/router_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/router_out_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: flit control bit positions, arbiter state type and credit defaults shared by the router output arbiter.
package router_pkg;
    localparam int FLIT_VALID_BIT = 0;
    localparam int FLIT_HEAD_BIT = 1;
    localparam int FLIT_TAIL_BIT = 2;
    localparam int CREDIT_MAX_DEFAULT = 8;
    localparam int MAX_IN = 8;
    typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [2:0]        ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [2:0]        idx
);
    logic [7:0] req8, grant8;
    logic [2:0] j;
    logic       found;
    always_comb begin
        req8 = 8'(req);
        grant8 = '0;
        idx = '0;
        found = 1'b0;
        j = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            j = 3'((int'(ptr) + k) % NUM_IN);
            if (!found && req8[j]) begin
                found = 1'b1;
                idx = j;
                grant8[j] = 1'b1;
            end
        end
    end
    assign grant = grant8[NUM_IN-1:0];
endmodule

// File: rtl/router_out_arbiter.sv
// router_out_arbiter: wormhole output-port arbiter with round-robin head grants and downstream credit metering.
// Optional ROUTER_ARB_WATCHDOG_EN breaks a LOCKED grant after 255 idle owner cycles.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int FLIT_W = 68,
    parameter int CREDIT_MAX = CREDIT_MAX_DEFAULT,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN*FLIT_W-1:0] req_flit,
    input  logic [NUM_IN-1:0]        req_valid,
    output logic [NUM_IN-1:0]        req_ready,
    output logic [0:FLIT_W-1]        channel_out_op,
    input  logic [0:1]               flow_ctrl_in_op,
    output logic [2:0]               grant_owner,
    output logic                     error
);
    arb_state_t        state;
    logic [2:0]        rr_ptr;
    logic [CNT_W-1:0]  credits;
    logic [FLIT_W-1:0] flits [MAX_IN];
    logic [MAX_IN-1:0] valid8, head8, tail8, lock_oh;
    logic [NUM_IN-1:0] idle_gnt;
    logic [2:0]        idle_idx, sel_idx;
    logic              has_credit, lock_ok, xfer, ret, full, lock_head_err, wd_fire;
    logic              unused_fc;
    assign unused_fc = flow_ctrl_in_op[1];
    // Pad requesters out to 8 so a 3-bit owner index always addresses a real entry.
    always_comb begin
        valid8 = MAX_IN'(req_valid);
        head8 = '0;
        tail8 = '0;
        for (int i = 0; i < MAX_IN; i++) flits[i] = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            flits[i] = req_flit[i*FLIT_W +: FLIT_W];
            head8[i] = flits[i][FLIT_HEAD_BIT];
            tail8[i] = flits[i][FLIT_TAIL_BIT];
        end
    end
    rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
        .req  (valid8[NUM_IN-1:0] & head8[NUM_IN-1:0]),
        .ptr  (rr_ptr),
        .grant(idle_gnt),
        .idx  (idle_idx)
    );
    assign has_credit = credits != '0;
    assign full = credits == CNT_W'(CREDIT_MAX);
    assign ret = flow_ctrl_in_op[0];
    assign lock_oh = MAX_IN'(1) << grant_owner;
    assign lock_ok = valid8[grant_owner] & ~head8[grant_owner];
    assign lock_head_err = state == LOCKED && valid8[grant_owner] && head8[grant_owner];
    assign req_ready = !has_credit ? '0 : state == IDLE ? idle_gnt : lock_ok ? lock_oh[NUM_IN-1:0] : '0;
    assign sel_idx = state == IDLE ? idle_idx : grant_owner;
    assign xfer = |req_ready;
`ifdef ROUTER_ARB_WATCHDOG_EN
    logic [7:0] wd_cnt;
    assign wd_fire = wd_cnt == 8'hFF;
    always_ff @(posedge clk) begin
        if (reset || wd_fire || xfer) wd_cnt <= '0;
        else if (state == LOCKED && !valid8[grant_owner]) wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_fire = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            credits <= CNT_W'(CREDIT_MAX);
            grant_owner <= '0;
            error <= 1'b0;
            channel_out_op <= '0;
        end else begin
            for (int k = 0; k < FLIT_W; k++) channel_out_op[k] <= xfer & flits[sel_idx][k];
            if (xfer && !ret) credits <= credits - 1'b1;
            else if (ret && !xfer && !full) credits <= credits + 1'b1;
            if (xfer) begin
                grant_owner <= sel_idx;
                state <= tail8[sel_idx] ? IDLE : LOCKED;
                if (state == IDLE) rr_ptr <= 3'((int'(sel_idx) + 1) % NUM_IN);
            end
            if ((ret && full) || lock_head_err || wd_fire) error <= 1'b1;
            if (wd_fire) state <= IDLE;
        end
    end
endmodule
